// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch and load/store ports share one memory, one
// transaction at a time, data favoured with a bounded fetch starvation window.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2,
    parameter int MAX_SKIP   = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_ack_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] d_be_i,
    output logic                    d_ack_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    busy_o,
    output logic [1:0]              state_o
);
    // Handshake: a requester raises req with stable qualifiers and holds them
    // until its one-cycle ack; req still high in the IDLE cycle after the ack
    // starts a new transaction, and a req dropped before its grant is forgotten.
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int SKIP_W   = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    grant_valid, grant_data, contested;
    logic [SKIP_W-1:0]       skip_q;
    logic [3:0]              wait_q;
    logic                    sel_data_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [BE_WIDTH-1:0]     be_q;
    logic [DATA_WIDTH-1:0]   if_rdata_q, d_rdata_q;

    assign contested = if_req_i && d_req_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_valid = 1'b0;
        grant_data  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Fetch only beats data once it has lost MAX_SKIP contests in a row.
                if (d_req_i && !(if_req_i && skip_q == SKIP_W'(MAX_SKIP))) begin
                    grant_valid = 1'b1;
                    grant_data  = 1'b1;
                end else if (if_req_i) begin
                    grant_valid = 1'b1;
                end
                if (grant_valid) state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (wait_q == 4'd1) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            skip_q     <= '0;
            wait_q     <= '0;
            sel_data_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_valid) begin
                        sel_data_q <= grant_data;
                        if (grant_data) begin
                            we_q    <= d_we_i;
                            addr_q  <= d_addr_i;
                            wdata_q <= d_wdata_i;
                            be_q    <= d_be_i;
                        end else begin
                            we_q    <= 1'b0;
                            addr_q  <= if_addr_i;
                            wdata_q <= '0;
                            be_q    <= '1;
                        end
                        if (!grant_data) begin
                            skip_q <= '0;
                        end else if (contested) begin
                            skip_q <= skip_q + 1'b1;
                        end
                    end
                end
                S_ISSUE: wait_q <= 4'(LATENCY);
                S_WAIT: begin
                    wait_q <= wait_q - 4'd1;
                    if (wait_q == 4'd1) begin
                        if (!sel_data_q) begin
                            if_rdata_q <= mem_rdata_i;
                        end else if (we_q) begin
                            d_rdata_q <= '0;
                        end else begin
                            d_rdata_q <= mem_rdata_i;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_o   = (state_q == S_ISSUE);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign if_ack_o    = (state_q == S_RESP) && !sel_data_q;
    assign d_ack_o     = (state_q == S_RESP) && sel_data_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign busy_o      = (state_q != S_IDLE);
    assign state_o     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch/load/store timing, skip-based priority,
// mid-transaction reset, and LATENCY=1/15 builds.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [31:0] cyc = 32'd0;
  int vec_count = 0;
  int err_count = 0;

  logic if_req, if_ack, d_req, d_we, d_ack;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0] d_be, mem_be;
  logic mem_req, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0] state;

  logic [31:0] rd_due = '1;
  logic [31:0] rd_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    return {a[15:0], 16'h0093} ^ 32'h13570000;
  endfunction

  // Memory model: the addressed word appears only LAT cycles after the strobe.
  always @(posedge clk) begin
    cyc <= cyc + 32'd1;
    if (mem_req) begin
      rd_due  <= cyc + LAT;
      rd_addr <= mem_addr;
    end
  end
  assign mem_rdata = (cyc == rd_due) ? mem_word(rd_addr) : {16'hBAD0, cyc[15:0]};

  mem_arbiter #(.LATENCY(LAT), .MAX_SKIP(3)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_be_i(d_be),
    .d_ack_o(d_ack), .d_rdata_o(d_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be), .mem_rdata_i(mem_rdata), .busy_o(busy), .state_o(state)
  );

  // Latency builds: memory returns a cycle stamp so capture timing is visible.
  logic zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;
  logic [3:0] zero4 = 4'h0;
  logic [31:0] stamp;
  assign stamp = {16'hC0DE, cyc[15:0]};
  logic l_if_req [2];
  logic [31:0] l_if_addr [2];
  logic l_if_ack [2], l_d_ack [2], l_mem_req [2], l_mem_we [2], l_busy [2];
  logic [31:0] l_if_rdata [2], l_d_rdata [2], l_mem_addr [2], l_mem_wdata [2];
  logic [3:0] l_mem_be [2];
  logic [1:0] l_state [2];

  for (genvar g = 0; g < 2; g++) begin : g_lat
    mem_arbiter #(.LATENCY(g == 0 ? 1 : 15), .MAX_SKIP(3)) u_lat (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(l_if_req[g]), .if_addr_i(l_if_addr[g]), .if_ack_o(l_if_ack[g]),
      .if_rdata_o(l_if_rdata[g]),
      .d_req_i(zero1), .d_we_i(zero1), .d_addr_i(zero32), .d_wdata_i(zero32), .d_be_i(zero4),
      .d_ack_o(l_d_ack[g]), .d_rdata_o(l_d_rdata[g]),
      .mem_req_o(l_mem_req[g]), .mem_we_o(l_mem_we[g]), .mem_addr_o(l_mem_addr[g]),
      .mem_wdata_o(l_mem_wdata[g]), .mem_be_o(l_mem_be[g]), .mem_rdata_i(stamp),
      .busy_o(l_busy[g]), .state_o(l_state[g])
    );
  end

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    for (int g = 0; g < 2; g++) begin
      l_if_req[g] = 1'b0; l_if_addr[g] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(output logic got, output logic is_data, output logic both,
                          output logic [31:0] at, output logic [31:0] rdata);
    got = 1'b0; is_data = 1'b0; both = 1'b0; at = '0; rdata = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        got = 1'b1; is_data = d_ack; both = if_ack && d_ack; at = cyc;
        rdata = d_ack ? d_rdata : if_rdata;
      end
    end
  endtask

  task automatic test_reset();
    logic [167:0] outs;
    do_reset();
    outs = {if_ack, d_ack, if_rdata, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, state};
    vec_count++;
    if (outs !== '0) begin
      err_count++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) @(negedge clk);
      vec_count++;
      if (mem_req !== (k == 1)) begin
        err_count++; $display("FAIL fetch_mem_req k=%0d: got %b expected %b", k, mem_req, k == 1);
      end
      vec_count++;
      if (busy !== (k >= 1 && k <= 4)) begin
        err_count++; $display("FAIL fetch_busy k=%0d: got %b expected %b", k, busy, k >= 1 && k <= 4);
      end
      vec_count++;
      if (if_ack !== (k == 4) || d_ack !== 1'b0) begin
        err_count++; $display("FAIL fetch_ack k=%0d: got if=%b d=%b expected if=%b d=0", k, if_ack, d_ack, k == 4);
      end
      if (k == 1) begin
        vec_count++;
        if ({mem_we, mem_addr, mem_be} !== {1'b0, 32'h0, 4'hF}) begin
          err_count++; $display("FAIL fetch_issue: got we=%b addr=%h be=%h expected 0/0/f", mem_we, mem_addr, mem_be);
        end
      end
      if (k == 4) begin
        vec_count++;
        if (if_rdata !== 32'h00500093) begin
          err_count++; $display("FAIL fetch_rdata: got %h expected 00500093", if_rdata);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = 4'hF;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) @(negedge clk);
      vec_count++;
      if (mem_req !== (k == 1)) begin
        err_count++; $display("FAIL data_mem_req k=%0d: got %b expected %b", k, mem_req, k == 1);
      end
      vec_count++;
      if (d_ack !== (k == 4) || if_ack !== 1'b0) begin
        err_count++; $display("FAIL data_ack k=%0d: got d=%b if=%b expected d=%b if=0", k, d_ack, if_ack, k == 4);
      end
      if (k >= 1 && k <= 3) begin
        vec_count++;
        if ({mem_we, mem_addr, mem_wdata, mem_be} !== {we, addr, wdata, 4'hF}) begin
          err_count++;
          $display("FAIL data_mem_bus k=%0d: got we=%b addr=%h wdata=%h be=%h expected %b/%h/%h/f",
                   k, mem_we, mem_addr, mem_wdata, mem_be, we, addr, wdata);
        end
      end
      if (k == 4) begin
        vec_count++;
        if (d_rdata !== exp_rdata) begin
          err_count++; $display("FAIL data_rdata: got %h expected %h", d_rdata, exp_rdata);
        end
        d_req = 1'b0;
      end
    end
  endtask

  // Runs both requesters against an expected grant order (1 = data, 0 = fetch).
  task automatic run_grants(input string name, input int drop_if_at, input int raise_if_at,
                            input logic check_spacing);
    logic [0:0] exp_q[$];
    logic [0:0] exp_g;
    logic got, is_data, both;
    logic [31:0] at, rdata, prev_at, exp_rd;
    int n;
    if (name == "contested") exp_q = '{1, 1, 1, 0, 1, 1, 1, 0};
    else exp_q = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
    prev_at = cyc;
    n = 0;
    while (exp_q.size() > 0) begin
      exp_g = exp_q.pop_front();
      wait_ack(got, is_data, both, at, rdata);
      vec_count++;
      if (!got) begin
        err_count++; $display("FAIL %s_timeout n=%0d: got no ack expected ack", name, n);
        break;
      end
      vec_count++;
      if (both !== 1'b0) begin
        err_count++; $display("FAIL %s_overlap n=%0d: got both acks expected one", name, n);
      end
      vec_count++;
      if (is_data !== exp_g) begin
        err_count++; $display("FAIL %s_order n=%0d: got data=%b expected data=%b", name, n, is_data, exp_g);
      end
      exp_rd = exp_g ? mem_word(32'h300) : mem_word(32'h40);
      vec_count++;
      if (rdata !== exp_rd) begin
        err_count++; $display("FAIL %s_rdata n=%0d: got %h expected %h", name, n, rdata, exp_rd);
      end
      if (check_spacing) begin
        vec_count++;
        if (at - prev_at !== (n == 0 ? 32'd4 : 32'd5)) begin
          err_count++; $display("FAIL %s_spacing n=%0d: got %0d expected %0d", name, n, at - prev_at, n == 0 ? 4 : 5);
        end
      end
      prev_at = at;
      if (n == drop_if_at) if_req = 1'b0;
      if (n == raise_if_at) if_req = 1'b1;
      n++;
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [167:0] outs;
    logic saw_dack, got, is_data, both;
    logic [31:0] at, rdata, t0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_be = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    outs = {if_ack, d_ack, if_rdata, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, state};
    vec_count++;
    if (outs !== '0) begin
      err_count++; $display("FAIL midreset_outputs: got %h expected 0", outs);
    end
    rst = 1'b0; d_req = 1'b0;
    saw_dack = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (d_ack) saw_dack = 1'b1;
    end
    vec_count++;
    if (saw_dack !== 1'b0) begin
      err_count++; $display("FAIL midreset_no_ack: got d_ack expected none");
    end
    if_req = 1'b1; if_addr = 32'h80;
    t0 = cyc;
    wait_ack(got, is_data, both, at, rdata);
    vec_count++;
    if ({got, is_data, at, rdata} !== {1'b1, 1'b0, t0 + 32'd4, mem_word(32'h80)}) begin
      err_count++;
      $display("FAIL midreset_refetch: got ack=%b data=%b at=%0d rdata=%h expected 1/0/%0d/%h",
               got, is_data, at, rdata, t0 + 32'd4, mem_word(32'h80));
    end
    if_req = 1'b0;
  endtask

  task automatic test_latency();
    int lat, ack_k, issue_k;
    logic [31:0] t0, e, got_rd, exp_rd;
    for (int g = 0; g < 2; g++) begin
      lat = (g == 0) ? 1 : 15;
      @(negedge clk);
      l_if_req[g] = 1'b1; l_if_addr[g] = 32'h20;
      t0 = cyc; ack_k = -1; issue_k = -1; got_rd = '0;
      for (int k = 1; k <= 22; k++) begin
        @(negedge clk);
        if (l_mem_req[g] && issue_k < 0) issue_k = k;
        if (l_if_ack[g] && ack_k < 0) begin
          ack_k = k; got_rd = l_if_rdata[g]; l_if_req[g] = 1'b0;
        end
      end
      vec_count++;
      if (issue_k != 1 || ack_k != lat + 2) begin
        err_count++; $display("FAIL latency%0d_timing: got issue=%0d ack=%0d expected 1/%0d", lat, issue_k, ack_k, lat + 2);
      end
      e = t0 + 32'd1 + 32'(lat);
      exp_rd = {16'hC0DE, e[15:0]};
      vec_count++;
      if (got_rd !== exp_rd) begin
        err_count++; $display("FAIL latency%0d_rdata: got %h expected %h", lat, got_rd, exp_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_data(1'b1, 32'h100, 32'hDEADBEEF, 32'h0);
    test_data(1'b0, 32'h200, 32'h0, mem_word(32'h200));
    do_reset();
    run_grants("contested", -1, -1, 1'b1);
    do_reset();
    run_grants("skip_hold", 1, 6, 1'b0);
    test_reset_mid();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
